// File: rtl/vedic_mult_pipe.sv
// Pipelined Vedic (Urdhva-Tiryagbhyam) multiplier, signed/unsigned.
// Three stages: operand magnitude, partial products, accumulate + sign.

module vedic_cell #(
    parameter int N = 2
) (
    input  logic [N-1:0]   x,
    input  logic [N-1:0]   y,
    output logic [2*N-1:0] p
);

    generate
        if (N == 2) begin : g_leaf
            // 2x2 vertical/crosswise cell
            logic c;
            assign c    = x[1] & y[0] & x[0] & y[1];
            assign p[0] = x[0] & y[0];
            assign p[1] = (x[1] & y[0]) ^ (x[0] & y[1]);
            assign p[2] = (x[1] & y[1]) ^ c;
            assign p[3] = x[1] & y[1] & c;
        end else begin : g_split
            localparam int M = N / 2;

            logic [N-1:0]   ll;
            logic [N-1:0]   lh;
            logic [N-1:0]   hl;
            logic [N-1:0]   hh;
            logic [2*N-1:0] mid;

            vedic_cell #(.N(M)) u_ll (
                .x(x[M-1:0]),
                .y(y[M-1:0]),
                .p(ll)
            );
            vedic_cell #(.N(M)) u_lh (
                .x(x[M-1:0]),
                .y(y[N-1:M]),
                .p(lh)
            );
            vedic_cell #(.N(M)) u_hl (
                .x(x[N-1:M]),
                .y(y[M-1:0]),
                .p(hl)
            );
            vedic_cell #(.N(M)) u_hh (
                .x(x[N-1:M]),
                .y(y[N-1:M]),
                .p(hh)
            );

            // crosswise terms summed once, then shifted into place
            assign mid = {{N{1'b0}}, lh} + {{N{1'b0}}, hl};
            assign p   = {hh, ll} + (mid << M);
        end
    endgenerate

endmodule

module vedic_mult_pipe #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               is_signed,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] result
);

    localparam int H  = WIDTH / 2;
    localparam int PW = 2 * WIDTH;

    logic             en;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;

    logic             v1;
    logic             neg1;
    logic [WIDTH-1:0] ma;
    logic [WIDTH-1:0] mb;

    logic             v2;
    logic             neg2;
    logic [WIDTH-1:0] ll_d;
    logic [WIDTH-1:0] lh_d;
    logic [WIDTH-1:0] hl_d;
    logic [WIDTH-1:0] hh_d;
    logic [WIDTH-1:0] ll_q;
    logic [WIDTH-1:0] lh_q;
    logic [WIDTH-1:0] hl_q;
    logic [WIDTH-1:0] hh_q;

    logic [PW-1:0]    mid;
    logic [PW-1:0]    mag;
    logic [PW-1:0]    fixed;

    // whole pipe moves together unless a result is waiting
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // -2^(W-1) negates to itself, which reads as 2^(W-1) unsigned
    always_comb begin
        abs_a = a;
        abs_b = b;
        if (is_signed && a[WIDTH-1]) abs_a = -a;
        if (is_signed && b[WIDTH-1]) abs_b = -b;
    end

    // S1: operand magnitudes and product sign
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1   <= 1'b0;
            neg1 <= 1'b0;
            ma   <= '0;
            mb   <= '0;
        end else if (en) begin
            v1   <= in_valid;
            neg1 <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            ma   <= abs_a;
            mb   <= abs_b;
        end
    end

    vedic_cell #(.N(H)) u_ll (
        .x(ma[H-1:0]),
        .y(mb[H-1:0]),
        .p(ll_d)
    );
    vedic_cell #(.N(H)) u_lh (
        .x(ma[H-1:0]),
        .y(mb[WIDTH-1:H]),
        .p(lh_d)
    );
    vedic_cell #(.N(H)) u_hl (
        .x(ma[WIDTH-1:H]),
        .y(mb[H-1:0]),
        .p(hl_d)
    );
    vedic_cell #(.N(H)) u_hh (
        .x(ma[WIDTH-1:H]),
        .y(mb[WIDTH-1:H]),
        .p(hh_d)
    );

    // S2: register the four half-width partial products
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2   <= 1'b0;
            neg2 <= 1'b0;
            ll_q <= '0;
            lh_q <= '0;
            hl_q <= '0;
            hh_q <= '0;
        end else if (en) begin
            v2   <= v1;
            neg2 <= neg1;
            ll_q <= ll_d;
            lh_q <= lh_d;
            hl_q <= hl_d;
            hh_q <= hh_d;
        end
    end

    // magnitude product never exceeds 2W bits, so no carry-out is kept
    always_comb begin
        mid   = {{WIDTH{1'b0}}, lh_q} + {{WIDTH{1'b0}}, hl_q};
        mag   = {hh_q, ll_q} + (mid << H);
        fixed = neg2 ? -mag : mag;
    end

    // S3: signed result; a zero magnitude negates to zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            result    <= '0;
        end else if (en) begin
            out_valid <= v2;
            result    <= fixed;
        end
    end

endmodule

// File: tb/tb_vedic_mult_pipe.sv
// Directed bench for vedic_mult_pipe, WIDTH=8.
// Table vectors, random stream, stall, reset-mid-pipe sequences.

module tb_vedic_mult_pipe;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        is_signed;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string      nm;
        logic [7:0] va;
        logic [7:0] vb;
        logic       sg;
        logic [15:0] ex;
    } vec_t;

    vec_t vecs[$];

    vedic_mult_pipe #(.WIDTH(8)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .a(a),
        .b(b),
        .is_signed(is_signed),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result(result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] model(input logic [7:0] x,
                                          input logic [7:0] y,
                                          input logic s);
        logic signed [15:0] sx;
        logic signed [15:0] sy;
        if (s) begin
            sx = {{8{x[7]}}, x};
            sy = {{8{y[7]}}, y};
            return sx * sy;
        end
        return {8'h00, x} * {8'h00, y};
    endfunction

    task automatic one_beat(input string nm, input logic [7:0] ta,
                            input logic [7:0] tb, input logic ts,
                            input logic [15:0] ex);
        int n;
        bit got;
        @(negedge clk);
        a = ta;
        b = tb;
        is_signed = ts;
        in_valid = 1'b1;
        out_ready = 1'b1;
        n = 0;
        got = 0;
        while (!got && n < 10) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            in_valid = 1'b0;
            if (out_valid) got = 1;
        end
        chk({nm, "_lat"}, n, 3);
        chk(nm, result, ex);
    endtask

    initial begin
        logic [15:0] q[$];
        logic [15:0] ex;
        logic [15:0] rr[3];
        logic [7:0]  bpa[3];
        logic [7:0]  bpb[3];
        logic [15:0] bpe[3];
        int sent;
        int got;
        int n;
        int k;
        bit started;

        rst = 1'b1;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        is_signed = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("rst_ov", out_valid, 0);
        chk("rst_res", result, 0);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_rdy", in_ready, 1);

        vecs.push_back('{"u5x2",    8'd5,   8'd2,   1'b0, 16'd10});
        vecs.push_back('{"u2x2",    8'd2,   8'd2,   1'b0, 16'd4});
        vecs.push_back('{"uffxff",  8'hFF,  8'hFF,  1'b0, 16'hFE01});
        vecs.push_back('{"s-3x7",   8'hFD,  8'h07,  1'b1, 16'hFFEB});
        vecs.push_back('{"s-128sq", 8'h80,  8'h80,  1'b1, 16'h4000});
        vecs.push_back('{"s-128x127", 8'h80, 8'h7F, 1'b1, 16'hC080});
        vecs.push_back('{"s0x-5",   8'h00,  8'hFB,  1'b1, 16'h0000});
        vecs.push_back('{"u80x2",   8'h80,  8'h02,  1'b0, 16'h0100});
        vecs.push_back('{"s80x2",   8'h80,  8'h02,  1'b1, 16'hFF00});
        vecs.push_back('{"u0xff",   8'h00,  8'hFF,  1'b0, 16'h0000});

        foreach (vecs[i])
            one_beat(vecs[i].nm, vecs[i].va, vecs[i].vb,
                     vecs[i].sg, vecs[i].ex);

        // random back-to-back stream, mixed modes
        @(negedge clk);
        sent = 0;
        got = 0;
        started = 0;
        n = 0;
        out_ready = 1'b1;
        while (got < 200 && n < 400) begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("stream_extra", out_valid, 0);
                end else begin
                    ex = q.pop_front();
                    chk("stream", result, ex);
                end
                got++;
                started = 1;
            end else if (started) begin
                chk("stream_gap", out_valid, 1);
            end
            if (sent < 200) begin
                a = 8'($urandom);
                b = 8'($urandom);
                is_signed = 1'($urandom);
                in_valid = 1'b1;
                q.push_back(model(a, b, is_signed));
                sent++;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        in_valid = 1'b0;
        chk("stream_cnt", got, 200);

        // backpressure: three beats then a 4-cycle stall
        bpa[0] = 8'd3; bpb[0] = 8'd4; bpe[0] = 16'd12;
        bpa[1] = 8'd6; bpb[1] = 8'd7; bpe[1] = 16'd42;
        bpa[2] = 8'd9; bpb[2] = 8'd9; bpe[2] = 16'd81;
        @(negedge clk);
        out_ready = 1'b1;
        is_signed = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a = bpa[i];
            b = bpb[i];
            in_valid = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("bp_rise", out_valid, 1);
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_hold_res", result, 12);
            chk("bp_hold_ov", out_valid, 1);
            chk("bp_hold_rdy", in_ready, 0);
        end
        out_ready = 1'b1;
        k = 0;
        n = 0;
        while (k < 3 && n < 10) begin
            if (out_valid) begin
                rr[k] = result;
                k++;
            end
            @(negedge clk);
            n++;
        end
        chk("bp_cnt", k, 3);
        for (int i = 0; i < 3; i++)
            chk("bp_order", rr[i], bpe[i]);
        chk("bp_dup", out_valid, 0);

        // asynchronous reset with beats in flight
        a = 8'd11;
        b = 8'd13;
        in_valid = 1'b1;
        @(negedge clk);
        a = 8'd7;
        b = 8'd9;
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        chk("rst_pre", result, 143);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_mid_ov", out_valid, 0);
        chk("rst_mid_res", result, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rst_stale", out_valid, 0);
        end
        one_beat("rst_fresh", 8'd3, 8'd5, 1'b0, 16'd15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vedic_mult_pipe.md
Name: vedic_mult_pipe

Overview:
Parametrised, pipelined Vedic (Urdhva-Tiryagbhyam) multiplier. It is the successor to the fixed 4x4 combinational multiplier and generalises operand width. It adds a signed/unsigned mode and a full 2*WIDTH result. It uses valid/ready handshakes on both sides so the datapath can sit between streaming blocks and accept backpressure.

Parameters:
WIDTH, 8, operand width in bits; power of two, at least 4; the result is 2*WIDTH bits.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous reset, active-high
in_valid  input  1  operand beat is valid
in_ready  output  1  block accepts the operand beat this cycle
a  input  WIDTH  multiplicand
b  input  WIDTH  multiplier
is_signed  input  1  1 = two's-complement operands; 0 = unsigned; sampled with a/b
out_valid  output  1  result beat is valid
out_ready  input  1  downstream accepts the result this cycle
result  output  2*WIDTH  product a*b, full width, no truncation

Behaviour:
- Reset: one clock, reset asynchronous and active-high. While rst is high, all stage valid flags clear, out_valid=0 and result=0. in_ready=1 after reset.
- Global enable: en = !out_valid || out_ready. All pipeline registers load only when en=1. in_ready = en, combinational.
- Transfers: input transfer on in_valid && in_ready. Output transfer on out_valid && out_ready.
- Stage S1, operand capture:
  - If is_signed=1, store magnitude |a| and |b| as WIDTH-bit unsigned values, plus neg = a[MSB] ^ b[MSB].
  - -2^(WIDTH-1) maps to magnitude 2^(WIDTH-1); this fits unsigned, so no overflow special case.
  - If is_signed=0, store a and b unchanged with neg=0.
  - v1 <= in_valid.
- Stage S2, partial products:
  - Let H = WIDTH/2. Split each magnitude into hi/lo halves.
  - Register four H x H products: ll = lo*lo, lh = lo_a*hi_b, hl = hi_a*lo_b, hh = hi*hi. Each is 2H bits.
  - Each H x H product is built as a Vedic vertical/crosswise array, recursing down to 2x2 cells via a generate block.
  - Carry v2 <= v1 and neg.
- Stage S3, accumulate and sign fix:
  - mag = ll + ((lh + hl) << H) + (hh << WIDTH), computed in 2*WIDTH+1 bits internally. Bit 2*WIDTH is always 0 and is dropped.
  - result <= neg ? (~mag + 1) : mag.
  - out_valid <= v2.
- Latency and throughput:
  - Latency is exactly 3 cycles from input transfer to out_valid, when not stalled.
  - Throughput is 1 result per cycle while out_ready=1.
- Stall:
  - When out_valid=1 and out_ready=0, every stage holds. result and out_valid stay stable until accepted. in_ready=0.
  - No beat is lost or duplicated.
  - Bubbles are not compressed during a stall.
- Simultaneous accept:
  - out_ready=1 with out_valid=1 and in_valid=1 in the same cycle: the output is consumed and the pipe advances. The new operand enters S1 in that same edge.
- Zero operand: a or b = 0 gives result 0 with neg forced irrelevant; -0 = 0.
- Reset mid-operation: all in-flight beats are discarded. The first out_valid after reset needs a new input transfer plus 3 cycles.
- is_signed is per-beat. Mixed modes back-to-back are legal and must not interact.

Test Plan:
1. WIDTH=8, unsigned: a=5, b=2, in_valid one cycle, out_ready=1 -> out_valid exactly 3 cycles later, result=16'd10. Repeat with a=2, b=2 -> 16'd4.
2. Unsigned max: a=8'hFF, b=8'hFF -> result=16'hFE01. Random back-to-back stream of 200 beats, out_ready=1 -> result matches the a*b reference model every cycle, one result per cycle.
3. Signed, each beat with is_signed=1, in order -> the matching results in order:
   - a=-3, b=7 -> 16'hFFEB.
   - a=-128, b=-128 -> 16'h4000.
   - a=-128, b=127 -> 16'hC080.
   - a=0, b=-5 -> 16'h0000.
4. Backpressure: three consecutive beats (3*4, 6*7, 9*9 unsigned), then out_ready low for 4 cycles once out_valid rises.
   - While stalled: result holds 16'd12 and in_ready=0.
   - After out_ready returns: results 12, 42, 81 in order, none lost or repeated.
5. Mixed mode: alternate is_signed=0 (a=8'h80, b=8'h02) and is_signed=1 (same operands).
   - Unsigned beat -> 16'h0100.
   - Signed beat -> 16'hFF00.
6. Reset mid-pipe: issue 2 beats, assert rst asynchronously between clock edges -> out_valid=0 and result=0 immediately, no stale result after release. A fresh beat appears 3 cycles after its input transfer.
